// File: rtl/mac_pkg.sv
// mac_pkg -- shared definitions for the MAC accumulation controller.
//   ACC_W        : accumulator width (fixed at 24 bits)
//   mac_state_e  : controller FSM state encoding (IDLE / ACCUM / DONE)
package mac_pkg;

  localparam int ACC_W = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } mac_state_e;

endpackage : mac_pkg

// File: rtl/mac_accum_ctrl_if.sv
// mac_accum_ctrl_if -- control and product-stream bundle for mac_accum_ctrl.
//   start/len/abort     : run control from the host
//   prod_valid/prod     : product beat from the multiplier
//   prod_ready          : controller accepts a beat this cycle
//   acc_out/ovf         : registered accumulator and sticky carry-out
//   busy/done           : run in progress / one-cycle completion pulse
//
// Handshake: a product beat transfers on a rising clk edge where prod_valid
// and prod_ready are both high. prod_ready is a function of controller state
// only and never looks at prod_valid; the producer may hold prod_valid high
// for any number of cycles and must keep prod stable until the transfer.
interface mac_accum_ctrl_if #(
  parameter int CNT_W  = 8,
  parameter int PROD_W = 16
);
  import mac_pkg::*;

  logic              start;
  logic [CNT_W-1:0]  len;
  logic              abort;
  logic              prod_valid;
  logic [PROD_W-1:0] prod;
  logic              prod_ready;
  logic [ACC_W-1:0]  acc_out;
  logic              ovf;
  logic              busy;
  logic              done;

  // Host / producer side.
  modport master (
    output start, len, abort, prod_valid, prod,
    input  prod_ready, acc_out, ovf, busy, done
  );

  // Controller side.
  modport slave (
    input  start, len, abort, prod_valid, prod,
    output prod_ready, acc_out, ovf, busy, done
  );

endinterface : mac_accum_ctrl_if

// File: rtl/adder_24bit.sv
// adder_24bit -- 24-bit ripple-carry adder used on the accumulator path.
//   a, b : addends
//   cin  : carry in
//   sum  : a + b + cin, low 24 bits
//   co   : carry out of bit 23
module adder_24bit
  import mac_pkg::*;
(
  input  logic [ACC_W-1:0] a,
  input  logic [ACC_W-1:0] b,
  input  logic             cin,
  output logic [ACC_W-1:0] sum,
  output logic             co
);

  always_comb begin
    logic carry;
    sum   = '0;
    carry = cin;
    for (int i = 0; i < ACC_W; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    co = carry;
  end

endmodule : adder_24bit

// File: rtl/mac_accum_ctrl.sv
// mac_accum_ctrl -- accumulates a host-specified number of unsigned product
// beats into a 24-bit register with a sticky carry-out flag.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : mac_accum_ctrl_if slave (start/len/abort, product stream,
//                acc_out/ovf/busy/done)
//   state_dbg  : current FSM state, for observation only
// A run starts in IDLE on start; len==0 completes immediately. Each accepted
// beat adds zext(prod) to the accumulator; the beat that drains the counter
// moves the FSM to DONE, which pulses done for one cycle and returns to IDLE.
// abort in ACCUM drops back to IDLE without a done pulse, keeping acc/ovf.
module mac_accum_ctrl
  import mac_pkg::*;
#(
  parameter int CNT_W  = 8,
  parameter int PROD_W = 16  // must be below ACC_W for the zero-extension
) (
  input  logic              clk,
  input  logic              rst_n,
  mac_accum_ctrl_if.slave   bus,
  output mac_state_e        state_dbg
);

  localparam int              PAD_W   = ACC_W - PROD_W;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  mac_state_e       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] sum;
  logic             carry_out;
  logic             in_accum;
  logic             beat_accept;

  assign prod_ext = {{PAD_W{1'b0}}, bus.prod};

  adder_24bit u_adder (
    .a   (acc_q),
    .b   (prod_ext),
    .cin (1'b0),
    .sum (sum),
    .co  (carry_out)
  );

  assign in_accum = (state_q == ST_ACCUM);
  // abort takes priority over a beat presented in the same cycle.
  assign beat_accept = in_accum && bus.prod_valid && !bus.abort;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          acc_d = '0;
          ovf_d = 1'b0;
          if (bus.len != '0) begin
            cnt_d   = bus.len;
            state_d = ST_ACCUM;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_ACCUM: begin
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (beat_accept) begin
          acc_d = sum;
          ovf_d = ovf_q | carry_out;
          cnt_d = cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  // All outputs are decoded from registers, so reset clears them at once.
  assign bus.prod_ready = in_accum;
  assign bus.busy       = in_accum;
  assign bus.done       = (state_q == ST_DONE);
  assign bus.acc_out    = acc_q;
  assign bus.ovf        = ovf_q;
  assign state_dbg      = state_q;

endmodule : mac_accum_ctrl

// File: tb/tb_mac_accum_ctrl.sv
// tb_mac_accum_ctrl -- directed bench for mac_accum_ctrl with a scoreboard
// of expected {ovf, acc_out} results per completed run.
module tb_mac_accum_ctrl;
  import mac_pkg::*;

  localparam int CNT_W  = 9;
  localparam int PROD_W = 16;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mac_accum_ctrl_if #(.CNT_W(CNT_W), .PROD_W(PROD_W)) ifc ();
  mac_state_e state_dbg;

  mac_accum_ctrl #(.CNT_W(CNT_W), .PROD_W(PROD_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (ifc),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [ACC_W:0]    exp_q[$];   // {ovf, acc}
  logic [PROD_W-1:0] beat_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change and outputs are sampled at the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Runs one accumulation of the beats in beat_q with `gap` idle cycles
  // between beats. noisy=1 also holds start high while busy and on the done
  // cycle, which the controller must ignore.
  task automatic run(input string tag, input int len, input int gap, input bit noisy);
    logic [ACC_W:0] acc_m;
    logic [ACC_W:0] exp_v;
    logic [ACC_W:0] got_v;
    int cyc, exp_lat, waited, early_done, rdy_drop;
    acc_m = '0;
    for (int i = 0; i < beat_q.size(); i++) begin
      acc_m = {1'b0, acc_m[ACC_W-1:0]} + {{(ACC_W+1-PROD_W){1'b0}}, beat_q[i]} | {acc_m[ACC_W], {ACC_W{1'b0}}};
    end
    exp_q.push_back(acc_m);
    exp_lat = (len == 0) ? 1 : 1 + len + gap * (len - 1);

    ifc.start = 1'b1;
    ifc.len   = CNT_W'(len);
    step();
    ifc.start  = 1'b0;
    cyc        = 1;
    early_done = 0;
    rdy_drop   = 0;
    for (int i = 0; i < beat_q.size(); i++) begin
      if (i != 0) begin
        for (int g = 0; g < gap; g++) begin
          ifc.prod_valid = 1'b0;
          ifc.prod       = PROD_W'($urandom_range(0, 65535));
          ifc.start      = noisy;
          if (ifc.busy !== 1'b1 || ifc.prod_ready !== 1'b1) rdy_drop++;
          if (ifc.done !== 1'b0) early_done++;
          step();
          cyc++;
        end
      end
      ifc.start      = 1'b0;
      ifc.prod_valid = 1'b1;
      ifc.prod       = beat_q[i];
      if (ifc.busy !== 1'b1 || ifc.prod_ready !== 1'b1) rdy_drop++;
      if (ifc.done !== 1'b0) early_done++;
      step();
      cyc++;
    end
    ifc.prod_valid = 1'b0;

    waited = 0;
    while (ifc.done !== 1'b1 && waited < 8) begin
      step();
      cyc++;
      waited++;
    end
    check({tag, "_done_seen"}, 32'(ifc.done), 32'd1);
    check({tag, "_done_latency"}, 32'(cyc), 32'(exp_lat));
    check({tag, "_ready_drop"}, 32'(rdy_drop), 32'd0);
    check({tag, "_early_done"}, 32'(early_done), 32'd0);
    check({tag, "_ready_at_done"}, 32'(ifc.prod_ready), 32'd0);
    got_v = {ifc.ovf, ifc.acc_out};
    if (exp_q.size() != 0) begin
      exp_v = exp_q.pop_front();
      check({tag, "_acc"}, 32'(got_v[ACC_W-1:0]), 32'(exp_v[ACC_W-1:0]));
      check({tag, "_ovf"}, 32'(got_v[ACC_W]), 32'(exp_v[ACC_W]));
    end
    ifc.start = noisy;
    step();
    ifc.start = 1'b0;
    check({tag, "_done_once"}, 32'(ifc.done), 32'd0);
    check({tag, "_idle_after"}, 32'(state_dbg), 32'(ST_IDLE));
    check({tag, "_busy_after"}, 32'(ifc.busy), 32'd0);
    beat_q.delete();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int len_r, gap_r;
    rst_n          = 1'b0;
    ifc.start      = 1'b0;
    ifc.len        = '0;
    ifc.abort      = 1'b0;
    ifc.prod_valid = 1'b0;
    ifc.prod       = '0;
    step();

    // Reset state
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    check("rst_acc", 32'(ifc.acc_out), 32'd0);
    check("rst_ovf", 32'(ifc.ovf), 32'd0);
    check("rst_busy", 32'(ifc.busy), 32'd0);
    check("rst_done", 32'(ifc.done), 32'd0);
    check("rst_ready", 32'(ifc.prod_ready), 32'd0);
    rst_n = 1'b1;
    step();

    // Back-to-back beats
    beat_q = '{16'h0010, 16'h0020, 16'h0030};
    run("b2b", 3, 0, 1'b0);

    // Stalls between beats, spurious start while busy and during done
    beat_q = '{16'hFFFF, 16'h0001};
    run("stall", 2, 5, 1'b1);

    // Zero-length run
    run("len0", 0, 0, 1'b0);

    // 257 x 0xFFFF wraps the accumulator and sets the sticky carry
    for (int i = 0; i < 257; i++) beat_q.push_back(16'hFFFF);
    run("wrap", 257, 0, 1'b0);
    ifc.abort = 1'b1;
    step();
    step();
    ifc.abort = 1'b0;
    step();
    check("wrap_hold_acc", 32'(ifc.acc_out), 32'h00FEFF);
    check("wrap_hold_ovf", 32'(ifc.ovf), 32'd1);
    check("idle_abort_state", 32'(state_dbg), 32'(ST_IDLE));

    // Random runs; a new start clears ovf
    for (int r = 0; r < 3; r++) begin
      len_r = $urandom_range(1, 6);
      gap_r = $urandom_range(0, 2);
      for (int i = 0; i < len_r; i++) beat_q.push_back(PROD_W'($urandom_range(0, 65535)));
      run("rand", len_r, gap_r, 1'b0);
    end

    // Abort coincident with the second beat
    ifc.start = 1'b1;
    ifc.len   = CNT_W'(4);
    step();
    ifc.start      = 1'b0;
    ifc.prod_valid = 1'b1;
    ifc.prod       = 16'h0123;
    exp_q.push_back({1'b0, 24'h000123});
    step();
    ifc.prod  = 16'h0456;
    ifc.abort = 1'b1;
    step();
    ifc.abort      = 1'b0;
    ifc.prod_valid = 1'b0;
    check("abort_state", 32'(state_dbg), 32'(ST_IDLE));
    check("abort_done", 32'(ifc.done), 32'd0);
    check("abort_busy", 32'(ifc.busy), 32'd0);
    if (exp_q.size() != 0) begin
      logic [ACC_W:0] ev;
      ev = exp_q.pop_front();
      check("abort_acc", 32'(ifc.acc_out), 32'(ev[ACC_W-1:0]));
      check("abort_ovf", 32'(ifc.ovf), 32'(ev[ACC_W]));
    end
    step();
    check("abort_no_late_done", 32'(ifc.done), 32'd0);

    // Reset asserted mid-run, checked before the next clock edge
    ifc.start = 1'b1;
    ifc.len   = CNT_W'(5);
    step();
    ifc.start      = 1'b0;
    ifc.prod_valid = 1'b1;
    ifc.prod       = 16'h0100;
    step();
    ifc.prod = 16'h0200;
    step();
    ifc.prod = 16'h0300;
    check("pre_rst_acc", 32'(ifc.acc_out), 32'h000300);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_acc", 32'(ifc.acc_out), 32'd0);
    check("mid_rst_ovf", 32'(ifc.ovf), 32'd0);
    check("mid_rst_busy", 32'(ifc.busy), 32'd0);
    check("mid_rst_ready", 32'(ifc.prod_ready), 32'd0);
    check("mid_rst_done", 32'(ifc.done), 32'd0);
    check("mid_rst_state", 32'(state_dbg), 32'(ST_IDLE));
    @(negedge clk);
    ifc.prod_valid = 1'b0;
    rst_n = 1'b1;
    step();
    check("post_rst_done", 32'(ifc.done), 32'd0);
    beat_q = '{16'h1111, 16'h2222};
    run("post_rst", 2, 1, 1'b0);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule : tb_mac_accum_ctrl
